// File: rtl/iq_interp_up.sv
// Dual (I/Q) 3-stage CIC interpolator with runtime ratio N and a valid/ready input slot.
// Optional macro IQ_INTERP_SAT_EN: output slice saturates instead of wrapping.
module iq_interp_up #(
    parameter int CNT_WIDTH    = 8,
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int GAIN_SHIFT   = 0
) (
    input  logic                           clk_in,
    input  logic                           RST,
    input  logic        [CNT_WIDTH-1:0]    N,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [INPUT_WIDTH-1:0]  I_IN,
    input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] I_OUT,
    output logic signed [OUTPUT_WIDTH-1:0] Q_OUT,
    output logic                           underrun
);
    localparam int ACC_WIDTH = INPUT_WIDTH + 2*CNT_WIDTH + 2;

    // state | meaning
    // IDLE  | waiting for the first sample; in_ready high once out of reset
    // RUN   | phase counter cycling, one input slot per N_eff output cycles
    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_next;
    logic                   armed;
    logic [CNT_WIDTH-1:0]   phase, phase_next, n_eff, n_eff_next, n_sel;
    logic                   accept, slot, slot_d;
    logic [3:0]             run_sr;

    logic signed [ACC_WIDTH-1:0] x     [2];
    logic signed [ACC_WIDTH-1:0] d1    [2];
    logic signed [ACC_WIDTH-1:0] d2    [2];
    logic signed [ACC_WIDTH-1:0] d3    [2];
    logic signed [ACC_WIDTH-1:0] dly   [2][3];
    logic signed [ACC_WIDTH-1:0] comb_reg [2];
    logic signed [ACC_WIDTH-1:0] integ [2][3];

    function automatic logic signed [OUTPUT_WIDTH-1:0] out_slice(input logic signed [ACC_WIDTH-1:0] v);
`ifdef IQ_INTERP_SAT_EN
        logic signed [ACC_WIDTH-1:0] upper;
        upper = v >>> (GAIN_SHIFT + OUTPUT_WIDTH - 1);
        if (upper != '0 && upper != '1)
            return v[ACC_WIDTH-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
`endif
        return v[GAIN_SHIFT +: OUTPUT_WIDTH];
    endfunction

    always_comb begin
        n_sel      = (N == '0 || N == CNT_WIDTH'(1)) ? CNT_WIDTH'(1) : N;
        state_next = state;
        phase_next = phase;
        n_eff_next = n_eff;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (in_valid && armed) begin
                    state_next = RUN;
                    n_eff_next = n_sel;
                    phase_next = (n_sel == CNT_WIDTH'(1)) ? '0 : CNT_WIDTH'(1);
                end
            end
            RUN: begin
                in_ready = (phase == '0);
                // Ratio changes only land on a block boundary.
                if (phase == n_eff - CNT_WIDTH'(1)) begin
                    phase_next = '0;
                    n_eff_next = n_sel;
                end else begin
                    phase_next = phase + CNT_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        accept = in_valid & in_ready;
        slot   = accept | (state == RUN && phase == '0);
    end

    always_comb begin
        x[0] = accept ? {{(ACC_WIDTH-INPUT_WIDTH){I_IN[INPUT_WIDTH-1]}}, I_IN} : '0;
        x[1] = accept ? {{(ACC_WIDTH-INPUT_WIDTH){Q_IN[INPUT_WIDTH-1]}}, Q_IN} : '0;
        for (int ch = 0; ch < 2; ch++) begin
            d1[ch] = x[ch]  - dly[ch][0];
            d2[ch] = d1[ch] - dly[ch][1];
            d3[ch] = d2[ch] - dly[ch][2];
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state     <= IDLE;
            armed     <= 1'b0;
            phase     <= '0;
            n_eff     <= CNT_WIDTH'(1);
            slot_d    <= 1'b0;
            run_sr    <= '0;
            underrun  <= 1'b0;
            I_OUT     <= '0;
            Q_OUT     <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                comb_reg[ch] <= '0;
                for (int s = 0; s < 3; s++) begin
                    dly[ch][s]   <= '0;
                    integ[ch][s] <= '0;
                end
            end
        end else begin
            state  <= state_next;
            armed  <= 1'b1;
            phase  <= phase_next;
            n_eff  <= n_eff_next;
            slot_d <= slot;
            run_sr <= {run_sr[2:0], state == RUN};
            if (state == RUN && phase == '0 && !in_valid)
                underrun <= 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                if (slot) begin
                    dly[ch][0]   <= x[ch];
                    dly[ch][1]   <= d1[ch];
                    dly[ch][2]   <= d2[ch];
                    comb_reg[ch] <= d3[ch];
                end
                // Zero-stuffing: the comb result enters integrator 1 only once per slot.
                if (state == RUN) begin
                    integ[ch][0] <= integ[ch][0] + (slot_d ? comb_reg[ch] : '0);
                    integ[ch][1] <= integ[ch][1] + integ[ch][0];
                    integ[ch][2] <= integ[ch][2] + integ[ch][1];
                end
            end
            I_OUT <= out_slice(integ[0][2]);
            Q_OUT <= out_slice(integ[1][2]);
        end
    end

    assign out_valid = run_sr[3];

endmodule

// File: tb/tb_iq_interp_up.sv
// Directed bench for iq_interp_up: reset, impulse, DC gain, handshake timing,
// underrun, N=1 pass-through, saturation/wrap and mid-run reset.
module tb_iq_interp_up;
    logic               clk_in = 1'b0;
    logic               RST;
    logic [7:0]         N;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] I_IN, Q_IN;
    logic               out_valid;
    logic signed [11:0] I_OUT, Q_OUT;
    logic               underrun;

    int errors = 0;
    int checks = 0;

    iq_interp_up #(.CNT_WIDTH(8), .INPUT_WIDTH(12), .OUTPUT_WIDTH(12), .GAIN_SHIFT(0)) dut (
        .clk_in(clk_in), .RST(RST), .N(N), .in_valid(in_valid), .in_ready(in_ready),
        .I_IN(I_IN), .Q_IN(Q_IN), .out_valid(out_valid), .I_OUT(I_OUT), .Q_OUT(Q_OUT),
        .underrun(underrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        I_IN = '0;
        Q_IN = '0;
        repeat (3) tick();
        chk("rst_i_out", I_OUT, 0);
        chk("rst_q_out", Q_OUT, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_underrun", {31'd0, underrun}, 0);
        RST = 1'b0;
        tick();
        chk("rel_in_ready", {31'd0, in_ready}, 1);
    endtask

    int imp [11] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

    initial begin
        N = 8'd4;
        do_reset();

        // Impulse, N=4
        N = 8'd4; I_IN = 12'sd1; Q_IN = 12'sd1; in_valid = 1'b1;
        tick();
        I_IN = '0; Q_IN = '0;
        repeat (3) tick();
        chk("imp_valid_t4", {31'd0, out_valid}, 0);
        chk("imp_i_t4", I_OUT, 0);
        tick();
        chk("imp_valid_t5", {31'd0, out_valid}, 1);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("imp_i_%0d", k), I_OUT, imp[k]);
            chk($sformatf("imp_q_%0d", k), Q_OUT, imp[k]);
            tick();
        end
        chk("imp_underrun", {31'd0, underrun}, 0);

        // DC, N=4: gain 16
        do_reset();
        N = 8'd4; I_IN = 12'sd1; Q_IN = -12'sd1; in_valid = 1'b1;
        repeat (20) tick();
        chk("dc_i_a", I_OUT, 16);
        chk("dc_q_a", Q_OUT, -16);
        tick();
        chk("dc_i_b", I_OUT, 16);
        chk("dc_q_b", Q_OUT, -16);

        // Handshake, N=8 then N=2 applied at the following wrap
        do_reset();
        N = 8'd8; I_IN = '0; Q_IN = '0; in_valid = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            tick();
            chk($sformatf("hs_ready_%0d", k), {31'd0, in_ready},
                (k <= 24) ? ((k % 8) == 0) : ((k % 2) == 0));
            if (k == 17) N = 8'd2;
        end

        // Underrun, N=4: slot at t+4 missed, zero must be used
        do_reset();
        N = 8'd4; I_IN = 12'sd1; Q_IN = 12'sd1; in_valid = 1'b1;
        tick();
        I_IN = 12'sd5; Q_IN = 12'sd5;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("ur_before", {31'd0, underrun}, 0);
        tick();
        in_valid = 1'b1; I_IN = '0; Q_IN = '0;
        chk("ur_set", {31'd0, underrun}, 1);
        chk("ur_i_t5", I_OUT, 1);
        repeat (4) tick();
        chk("ur_i_t9", I_OUT, 12);
        chk("ur_q_t9", Q_OUT, 12);
        tick();
        chk("ur_i_t10", I_OUT, 12);
        chk("ur_sticky", {31'd0, underrun}, 1);

        // Mid-run reset
        RST = 1'b1;
        tick();
        chk("mr_underrun", {31'd0, underrun}, 0);
        chk("mr_out_valid", {31'd0, out_valid}, 0);
        chk("mr_i_out", I_OUT, 0);
        chk("mr_in_ready", {31'd0, in_ready}, 0);
        RST = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("mr_idle_ready", {31'd0, in_ready}, 1);

        // N=1: ready every cycle, unity pass-through with 5-cycle latency
        N = 8'd1; in_valid = 1'b1; I_IN = 12'sd3; Q_IN = -12'sd4;
        tick();
        I_IN = -12'sd2; Q_IN = 12'sd5;
        chk("n1_ready_1", {31'd0, in_ready}, 1);
        tick();
        I_IN = 12'sd7; Q_IN = 12'sd0;
        chk("n1_ready_2", {31'd0, in_ready}, 1);
        tick();
        I_IN = '0; Q_IN = '0;
        chk("n1_ready_3", {31'd0, in_ready}, 1);
        repeat (2) tick();
        chk("n1_i_0", I_OUT, 3);
        chk("n1_q_0", Q_OUT, -4);
        tick();
        chk("n1_i_1", I_OUT, -2);
        chk("n1_q_1", Q_OUT, 5);
        tick();
        chk("n1_i_2", I_OUT, 7);
        chk("n1_q_2", Q_OUT, 0);
        chk("n1_underrun", {31'd0, underrun}, 0);

        // Full-scale DC at N=16: gain 256 overflows the 12-bit slice
        do_reset();
        N = 8'd16; I_IN = 12'sd2047; Q_IN = -12'sd2048; in_valid = 1'b1;
        repeat (80) tick();
`ifdef IQ_INTERP_SAT_EN
        chk("sat_i", I_OUT, 2047);
        chk("sat_q", Q_OUT, -2048);
`else
        chk("wrap_i", I_OUT, -256);
        chk("wrap_q", Q_OUT, 0);
`endif
        chk("sat_out_valid", {31'd0, out_valid}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
